// File: rtl/renode_pkg.sv
// Shared types for the Renode co-simulation bridge and its bus-side helpers.
package renode_pkg;

  typedef logic [31:0] address_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    Idle,
    Setup,
    Access,
    Respond
  } apb_manager_state_e;

endpackage

// File: rtl/renode_timeout_counter.sv
// Cycle counter that flags the final permitted wait cycle; Limit=0 disables it.
module renode_timeout_counter #(
  parameter int Limit = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CountWidth = (Limit > 0) ? $clog2(Limit + 1) : 1;

  generate
    if (Limit > 0) begin : g_count
      localparam logic [CountWidth-1:0] Last = CountWidth'(Limit - 1);

      logic [CountWidth-1:0] count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + 1'b1;
        end
      end

      // Asserted on the cycle whose increment would bring the count to Limit.
      assign expired = enable && (count == Last);
    end else begin : g_inert
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/renode_apb3_manager.sv
// APB3 requester: turns single bridge requests into one SETUP/ACCESS transfer with timeout.
module renode_apb3_manager
  import renode_pkg::*;
#(
  parameter int AddressWidth  = $bits(address_t),
  parameter int DataWidth     = $bits(data_t),
  parameter int TimeoutCycles = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [AddressWidth-1:0] paddr,
  output logic [DataWidth-1:0]    pwdata,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  apb_manager_state_e state, next_state;
  logic               expired;

  renode_timeout_counter #(
    .Limit(TimeoutCycles)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == Setup),
    .enable ((state == Access) && !pready),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Idle;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      Idle:    if (req_valid) next_state = Setup;
      Setup:   next_state = Access;
      Access:  if (pready || expired) next_state = Respond;
      Respond: if (rsp_ready) next_state = Idle;
      default: next_state = Idle;
    endcase
  end

  // Handshake and bus strobes are flops decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (next_state == Idle);
      psel      <= (next_state == Setup) || (next_state == Access);
      penable   <= (next_state == Access);
      rsp_valid <= (next_state == Respond);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == Idle && req_valid) begin
        pwrite <= req_write;
        paddr  <= req_addr;
        pwdata <= req_wdata;
      end
      // pready takes priority over a timeout landing on the same edge.
      if (state == Access) begin
        if (pready) begin
          rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
          rsp_error   <= pslverr;
          rsp_timeout <= 1'b0;
        end else if (expired) begin
          rsp_rdata   <= '0;
          rsp_error   <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
      if (state == Respond && rsp_ready) begin
        rsp_rdata   <= '0;
        rsp_error   <= 1'b0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_renode_apb3_manager.sv
// Self-checking bench for renode_apb3_manager: directed table, corner sequences, random traffic.
module tb_renode_apb3_manager;
  import renode_pkg::*;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] cfg_prdata = '0;
  logic        cfg_slverr = 1'b0;
  int          cfg_wait = 0;
  int          acc_idx = 0;

  logic [31:0] got_rdata;
  logic        got_error, got_timeout;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          wait_k;
    int          rsp_delay;
    logic [31:0] exp_rdata;
    logic        exp_error;
    logic        exp_timeout;
    int          exp_latency;
  } vec_t;

  vec_t vecs[7];

  renode_apb3_manager #(
    .AddressWidth (32),
    .DataWidth    (32),
    .TimeoutCycles(T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  // Peripheral model: raises pready on the (cfg_wait+1)-th ACCESS cycle.
  always @(negedge clk) begin
    if (psel && penable) begin
      pready  = (acc_idx == cfg_wait);
      pslverr = pready & cfg_slverr;
      prdata  = pready ? cfg_prdata : 32'h5A5A_5A5A;
      acc_idx = acc_idx + 1;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      acc_idx = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: response derived from wait length, error flag and timeout limit.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_timeout = (v.wait_k >= T);
    r.exp_error   = r.exp_timeout || v.slverr;
    r.exp_rdata   = (v.write || r.exp_error) ? 32'h0 : v.prdata;
    r.exp_latency = 2 + (r.exp_timeout ? T : v.wait_k + 1);
    return r;
  endfunction

  // Runs one full transfer and checks bus stability, response hold and handshake.
  task automatic applyStimulus(input vec_t v, input string tag, output int lat, output int acc);
    logic        stable;
    logic        hold_ok;
    @(negedge clk);
    checkOutput({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_write  = v.write;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    cfg_prdata = v.prdata;
    cfg_slverr = v.slverr;
    cfg_wait   = v.wait_k;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    lat    = 1;
    acc    = 0;
    stable = 1'b1;
    while (!rsp_valid && lat < 400) begin
      if (!psel || req_ready) stable = 1'b0;
      if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.write) stable = 1'b0;
      if (psel && penable) acc++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".bus_stable"}, {31'h0, stable}, 32'h1);
    checkOutput({tag, ".bus_released"}, {30'h0, psel, penable}, 32'h0);
    got_rdata   = rsp_rdata;
    got_error   = rsp_error;
    got_timeout = rsp_timeout;
    hold_ok     = 1'b1;
    for (int d = 0; d < v.rsp_delay; d++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== got_rdata ||
          rsp_error !== got_error || rsp_timeout !== got_timeout) hold_ok = 1'b0;
    end
    if (v.rsp_delay > 0) checkOutput({tag, ".rsp_hold"}, {31'h0, hold_ok}, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, ".after_hs"}, {28'h0, req_ready, rsp_valid, rsp_error, rsp_timeout}, 32'h8);
    checkOutput({tag, ".after_hs_rdata"}, rsp_rdata, 32'h0);
  endtask

  task automatic runAndCompare(input vec_t v, input string tag);
    int lat, acc;
    applyStimulus(v, tag, lat, acc);
    checkOutput({tag, ".latency"}, lat, v.exp_latency);
    checkOutput({tag, ".access_cycles"}, acc, v.exp_latency - 2);
    checkOutput({tag, ".rdata"}, got_rdata, v.exp_rdata);
    checkOutput({tag, ".error"}, {31'h0, got_error}, {31'h0, v.exp_error});
    checkOutput({tag, ".timeout"}, {31'h0, got_timeout}, {31'h0, v.exp_timeout});
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 0,   0, 32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b1, 32'h2004, 32'h12345678, 32'hAAAA5555, 1'b0, 3,   0, 32'h0,        1'b0, 1'b0, 6};
    vecs[2] = '{1'b0, 32'h3000, 32'h0,        32'h0BADF00D, 1'b1, 1,   0, 32'h0,        1'b1, 1'b0, 4};
    vecs[3] = '{1'b0, 32'h4000, 32'h0,        32'h11111111, 1'b0, 200, 0, 32'h0,        1'b1, 1'b1, 102};
    vecs[4] = '{1'b0, 32'h5008, 32'h0,        32'hCAFE0001, 1'b0, 2,   5, 32'hCAFE0001, 1'b0, 1'b0, 5};
    vecs[5] = '{1'b0, 32'h600C, 32'h0,        32'h0000BEEF, 1'b0, 99,  0, 32'h0000BEEF, 1'b0, 1'b0, 102};
    vecs[6] = '{1'b1, 32'h7010, 32'hFFFF0000, 32'h0,        1'b1, 0,   2, 32'h0,        1'b1, 1'b0, 3};

    repeat (3) @(negedge clk);
    checkOutput("reset.ready_valid", {30'h0, req_ready, rsp_valid}, 32'h2);
    checkOutput("reset.flags", {27'h0, rsp_error, rsp_timeout, psel, penable, pwrite}, 32'h0);
    checkOutput("reset.rdata", rsp_rdata, 32'h0);
    checkOutput("reset.paddr", paddr, 32'h0);
    checkOutput("reset.pwdata", pwdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) runAndCompare(vecs[i], $sformatf("vec%0d", i));

    // Reset during ACCESS drops the transfer without a response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8888; req_wdata = 32'h9999;
    cfg_wait = 500; cfg_slverr = 1'b0; cfg_prdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst.in_access", {30'h0, psel, penable}, 32'h3);
    rst = 1'b1;
    #1;
    checkOutput("midrst.ready_valid", {30'h0, req_ready, rsp_valid}, 32'h2);
    checkOutput("midrst.flags", {27'h0, rsp_error, rsp_timeout, psel, penable, pwrite}, 32'h0);
    checkOutput("midrst.paddr", paddr, 32'h0);
    checkOutput("midrst.pwdata", pwdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst.no_stale", {31'h0, rsp_valid}, 32'h0);
    end
    runAndCompare(vecs[0], "postrst");

    for (int i = 0; i < 40; i++) begin
      v.write     = $urandom_range(0, 1) == 1;
      v.addr      = $urandom;
      v.wdata     = $urandom;
      v.prdata    = $urandom;
      v.slverr    = $urandom_range(0, 3) == 0;
      v.wait_k    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(97, 103)) : int'($urandom_range(0, 5));
      v.rsp_delay = $urandom_range(0, 3);
      runAndCompare(model(v), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/renode_apb3_manager.md
# renode_apb3_manager

Synthesizable APB3 requester that sits directly downstream of the Renode co-simulation bridge's bus-controller side. It accepts single read/write requests from the bridge, converts each into one APB3 SETUP/ACCESS transfer on the DUT bus, and returns data plus error/timeout status. Because the timeout is enforced in RTL, a stalled peripheral never hangs the bridge.

## Interface
- AddressWidth, 32: width of req_addr/paddr; matches renode_pkg::address_t.
- DataWidth, 32: width of data paths; matches renode_pkg::data_t.
- TimeoutCycles, 100: maximum ACCESS cycles waiting for pready. 0 disables the timeout.
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  AddressWidth  target address.
- req_wdata  input  DataWidth  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DataWidth  read data. Always 0 for writes and errors.
- rsp_error  output  1  pslverr seen or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- psel, penable, pwrite  output  1  APB3 control.
- paddr  output  AddressWidth  APB3 address.
- pwdata  output  DataWidth  APB3 write data.
- prdata  input  DataWidth  APB3 read data.
- pready, pslverr  input  1  APB3 completion and error.

## Operation
- FSM states and transitions:
  - IDLE -> SETUP when req_valid && req_ready.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> RESPOND on pready, or on timeout.
  - RESPOND -> IDLE when rsp_ready.
- IDLE: req_ready=1. All other states: req_ready=0. Exactly one outstanding transfer.
- On accept: latch req_write, req_addr and req_wdata into registers that drive pwrite/paddr/pwdata. These hold stable through SETUP and ACCESS.
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1. When pready=1:
  - Capture prdata (reads only) and pslverr.
  - Set rsp_error=pslverr, rsp_timeout=0.
- Timeout:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TimeoutCycles, the FSM leaves ACCESS with rsp_error=1, rsp_timeout=1, rsp_rdata=0. The APB bus is released in that same transition.
  - Counter width is $clog2(TimeoutCycles+1).
  - With TimeoutCycles=0 the counter is inert and the FSM waits indefinitely.
- If pslverr=1, rsp_rdata=0.
- RESPOND: rsp_valid=1. Response fields are held stable until rsp_ready, then go to 0 on exit.
- Reset mid-operation: the in-flight transfer is dropped, no response is produced, and the FSM goes to IDLE.

## Timing
- Reset values:
  - req_ready=1.
  - rsp_valid, rsp_error, rsp_timeout, psel, penable, pwrite = 0.
  - rsp_rdata, paddr, pwdata = 0.
- All outputs are registered. No combinational path from any input to any output.
- Minimum latency, with pready=1 on the first ACCESS cycle:
  - accept at edge N;
  - SETUP in cycle N+1;
  - ACCESS in cycle N+2;
  - rsp_valid in cycle N+3.
- With k wait cycles, rsp_valid is at N+3+k.
- Timeout: with pready held 0, ACCESS lasts TimeoutCycles cycles. rsp_valid rises in the cycle after the last one.
- pready=1 on the same edge the count reaches TimeoutCycles: pready wins and a normal completion is reported.
- rsp_ready=1 on the first RESPOND cycle: single-cycle response, and req_ready=1 in the next cycle.
- Back-to-back throughput: one transfer per 4 cycles minimum.
- psel and penable both return to 0 in the cycle after ACCESS ends.

## Structure
- Use the existing renode_pkg::address_t and renode_pkg::data_t for defaults.
- Add typedef enum apb_manager_state_e {Idle, Setup, Access, Respond} to renode_pkg for bench visibility.
- One sub-module: renode_timeout_counter (parameter Limit; ports clk, rst, clear, enable, expired). The bridge-side timeout in the bus controller path reuses it.

## Test plan
- Read 0x1000, prdata=0xDEADBEEF, pready=1 at first ACCESS -> rsp_valid at N+3, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Write 0x2004 data 0x12345678, pready after 3 wait cycles -> pwdata/paddr stable across SETUP+ACCESS, rsp_valid at N+6, rsp_rdata=0.
- Read with pslverr=1 at completion -> rsp_error=1, rsp_timeout=0, rsp_rdata=0.
- TimeoutCycles=100, pready stuck 0 -> exactly 100 ACCESS cycles, then psel=0, rsp_error=1, rsp_timeout=1.
- rsp_ready held 0 for 5 cycles -> response fields stable, req_ready=0 throughout, next request accepted the cycle after the handshake.
- rst asserted during ACCESS -> all outputs at reset values immediately. After release, a new read completes normally with no stale response.
